matrix_weight_reader: RTL and testbench

//   Initiator side of the weight-matrix ROM interface: walks a rows x cols weight block row-major,

---
 rtl/matrix_weight_reader.sv | 157 +++++++++++++++
 tb/tb_matrix_weight_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_weight_reader.sv
// matrix_weight_reader: walks a rows x cols weight block row-major through a
// combinational ROM and streams the weights to the MAC datapath over a
// valid/ready handshake, decoupled by a 2-entry output buffer.
module matrix_weight_reader #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DIM_W     = 12,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DIM_W-1:0]  num_rows,
   input  logic [DIM_W-1:0]  num_cols,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   input  logic [DATA_W-1:0] mem_data,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [DATA_W-1:0] w_data,
   output logic              w_last_col,
   output logic              w_last
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state, state_nx;
   logic [DIM_W-1:0]  rows_r, cols_r, row, col;
   logic [DATA_W-1:0] d0, d1;
   logic              lc0, lc1, l0, l1;
   logic [1:0]        count;
   logic              full, pop, push, accept_start, zero_start, final_pop;
   logic              el_last_col, el_last;

   assign full        = (count == 2'(BUF_DEPTH));
   assign pop         = (count != 2'd0) && w_ready;
   assign el_last_col = (col == cols_r - DIM_W'(1));
   assign el_last     = el_last_col && (row == rows_r - DIM_W'(1));

   assign w_valid    = (count != 2'd0);
   assign w_data     = d0;
   assign w_last_col = lc0;
   assign w_last     = l0;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state and per-cycle control decode
   always_comb begin
      state_nx     = state;
      push         = 1'b0;
      accept_start = 1'b0;
      zero_start   = 1'b0;
      final_pop    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (num_rows != '0 && num_cols != '0) begin
                  accept_start = 1'b1;
                  state_nx     = RUN;
               end else begin
                  zero_start = 1'b1;
               end
            end
         end
         RUN: begin
            // A full buffer still accepts when its head leaves on the same edge
            if (!full || pop) begin
               push = 1'b1;
               if (el_last) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && l0) begin
               final_pop = 1'b1;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Walk bookkeeping: dimensions, row/col counters, ROM address, status
   always_ff @(posedge clk) begin
      if (reset) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_address <= '0;
         rows_r      <= '0;
         cols_r      <= '0;
         row         <= '0;
         col         <= '0;
      end else begin
         done <= zero_start | final_pop;
         if (accept_start) begin
            busy        <= 1'b1;
            rows_r      <= num_rows;
            cols_r      <= num_cols;
            row         <= '0;
            col         <= '0;
            mem_address <= base_addr;
         end else if (push) begin
            mem_address <= mem_address + ADDR_W'(1);
            if (el_last_col) begin
               col <= '0;
               row <= row + DIM_W'(1);
            end else begin
               col <= col + DIM_W'(1);
            end
         end
         if (final_pop) busy <= 1'b0;
      end
   end

   // Two-entry output buffer; entry 0 is always the head presented on w_*
   always_ff @(posedge clk) begin
      if (reset) begin
         d0    <= '0;
         d1    <= '0;
         lc0   <= 1'b0;
         lc1   <= 1'b0;
         l0    <= 1'b0;
         l1    <= 1'b0;
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  d0 <= mem_data; lc0 <= el_last_col; l0 <= el_last;
               end else begin
                  d1 <= mem_data; lc1 <= el_last_col; l1 <= el_last;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               d0 <= d1; lc0 <= lc1; l0 <= l1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  d0 <= mem_data; lc0 <= el_last_col; l0 <= el_last;
               end else begin
                  d0 <= d1; lc0 <= lc1; l0 <= l1;
                  d1 <= mem_data; lc1 <= el_last_col; l1 <= el_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_weight_reader.sv
// Scoreboard bench for matrix_weight_reader: stimulus queues expected words,
// a negedge monitor pops and compares every handshake and every done pulse.
module tb_matrix_weight_reader;

   logic        clk = 1'b0;
   logic        reset, start, busy, done, w_valid, w_ready, w_last_col, w_last;
   logic [15:0] base_addr, mem_address;
   logic [11:0] num_rows, num_cols;
   logic [31:0] mem_data, w_data;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [15:0] a);
      return {a ^ 16'h5A5A, ~a};
   endfunction

   assign mem_data = rom(mem_address);

   matrix_weight_reader #(.ADDR_W(16), .DATA_W(32), .DIM_W(12), .BUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .num_rows(num_rows), .num_cols(num_cols), .busy(busy), .done(done),
      .mem_address(mem_address), .mem_data(mem_data), .w_valid(w_valid),
      .w_ready(w_ready), .w_data(w_data), .w_last_col(w_last_col), .w_last(w_last)
   );

   typedef struct packed {logic [31:0] d; logic lc; logic l;} exp_t;
   exp_t q[$];

   int checks = 0, errors = 0;
   int rx_count = 0, done_count = 0, cyc = 0, last_pop_cyc = -10;
   bit zero_mode = 1'b0, done_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare each accepted word against the scoreboard; police done
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!reset) begin
         if (w_valid && q.size() == 0) begin
            check("spurious_valid", {63'd0, w_valid}, 64'd0);
         end else if (w_valid && w_ready) begin
            e = q.pop_front();
            check("w_data", {32'd0, w_data}, {32'd0, e.d});
            check("w_last_col", {63'd0, w_last_col}, {63'd0, e.lc});
            check("w_last", {63'd0, w_last}, {63'd0, e.l});
            rx_count++;
            if (w_last) last_pop_cyc = cyc;
         end
         if (done) begin
            check("done_busy_excl", {63'd0, busy}, 64'd0);
            check("done_once", {63'd0, done_prev}, 64'd0);
            if (!zero_mode) check("done_latency", 64'(cyc), 64'(last_pop_cyc + 1));
            done_count++;
         end
      end
      done_prev = done;
   end

   task automatic push_walk(input logic [15:0] base, input int rows, input int cols);
      int n = rows * cols;
      for (int i = 0; i < n; i++) begin
         exp_t e;
         logic [15:0] a = base + 16'(i);
         e.d  = rom(a);
         e.lc = ((i % cols) == cols - 1);
         e.l  = (i == n - 1);
         q.push_back(e);
      end
   endtask

   // Returns one time unit after the edge that samples start
   task automatic pulse_start(input logic [15:0] base, input int rows, input int cols);
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; num_rows = 12'(rows); num_cols = 12'(cols);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int d0 = done_count;
      int n = 0;
      while (done_count == d0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 64'(done_count - d0), 64'd1);
   endtask

   task automatic wait_rx(input int target, input string name);
      int n = 0;
      while (rx_count < target && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 64'(rx_count), 64'(target));
   endtask

   initial begin
      int r0;
      reset = 1'b1; start = 1'b0; w_ready = 1'b1;
      base_addr = '0; num_rows = '0; num_cols = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_valid", {63'd0, w_valid}, 64'd0);
      check("rst_data", {32'd0, w_data}, 64'd0);
      check("rst_flags", {62'd0, w_last_col, w_last}, 64'd0);
      check("rst_addr", {48'd0, mem_address}, 64'd0);

      // 1) 2x3 walk at full throughput
      push_walk(16'h0010, 2, 3);
      pulse_start(16'h0010, 2, 3);
      check("t1_busy", {63'd0, busy}, 64'd1);
      check("t1_valid_e0", {63'd0, w_valid}, 64'd0);
      check("t1_addr_e0", {48'd0, mem_address}, 64'h10);
      @(posedge clk); #1;
      check("t1_valid_e1", {63'd0, w_valid}, 64'd1);
      check("t1_addr_e1", {48'd0, mem_address}, 64'h11);
      wait_done("t1_done");
      check("t1_drained", 64'(q.size()), 64'd0);
      check("t1_idle", {63'd0, busy}, 64'd0);

      // 2) consumer stall after word 2
      r0 = rx_count;
      push_walk(16'h0010, 2, 3);
      pulse_start(16'h0010, 2, 3);
      wait_rx(r0 + 2, "t2_two_words");
      w_ready = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         check("t2_hold_data", {32'd0, w_data}, {32'd0, rom(16'h0012)});
         check("t2_hold_valid", {63'd0, w_valid}, 64'd1);
         check("t2_hold_addr", {48'd0, mem_address}, 64'h14);
      end
      w_ready = 1'b1;
      wait_done("t2_done");
      check("t2_count", 64'(rx_count - r0), 64'd6);

      // 3) zero-size start
      zero_mode = 1'b1;
      pulse_start(16'h0020, 0, 4);
      check("t3_done", {63'd0, done}, 64'd1);
      check("t3_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      check("t3_done_off", {63'd0, done}, 64'd0);
      repeat (3) begin
         @(posedge clk); #1;
         check("t3_no_valid", {63'd0, w_valid}, 64'd0);
      end
      zero_mode = 1'b0;

      // 4) start during busy is ignored
      push_walk(16'h0030, 2, 3);
      pulse_start(16'h0030, 2, 3);
      @(posedge clk); #1;
      check("t4_busy", {63'd0, busy}, 64'd1);
      start = 1'b1; base_addr = 16'h0100; num_rows = 12'd1; num_cols = 12'd1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("t4_done");
      check("t4_drained", 64'(q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1 check("t4_no_restart", {63'd0, busy}, 64'd0);

      // 5) address wrap
      push_walk(16'hFFFE, 1, 4);
      pulse_start(16'hFFFE, 1, 4);
      wait_done("t5_done");
      check("t5_drained", 64'(q.size()), 64'd0);
      check("t5_addr_end", {48'd0, mem_address}, 64'h0002);

      // 6) reset mid-walk, then a clean walk
      r0 = rx_count;
      push_walk(16'h0040, 3, 3);
      pulse_start(16'h0040, 3, 3);
      wait_rx(r0 + 2, "t6_two_words");
      reset = 1'b1;
      q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      check("t6_busy", {63'd0, busy}, 64'd0);
      check("t6_valid", {63'd0, w_valid}, 64'd0);
      check("t6_addr", {48'd0, mem_address}, 64'd0);
      r0 = rx_count;
      push_walk(16'h0040, 3, 3);
      pulse_start(16'h0040, 3, 3);
      wait_done("t6_done");
      check("t6_count", 64'(rx_count - r0), 64'd9);
      check("t6_drained", 64'(q.size()), 64'd0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
